// File: rtl/keypad_scan_debounce.sv
// keypad_scan_debounce
// Scans a 4x4 active-low key matrix one column at a time, debounces whole
// scans, rejects multi-key chords and emits one single-cycle {1,col,row}
// event per press on value.
// Optional feature macro: AUTOREPEAT_EN adds held-key auto-repeat events.
//
// state   | meaning
// IDLE    | no key accepted; waiting for a stable single key
// PRESSED | event sent for held key; waiting for a stable full release
module keypad_scan_debounce #(
    parameter int SCAN_DIV            = 50000,
    parameter int DEBOUNCE_SCANS      = 8,
    parameter int REPEAT_DELAY_SCANS  = 500,
    parameter int REPEAT_PERIOD_SCANS = 100
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] columns,
    output logic [4:0] value,
    output logic       key_held
);

    localparam int DIV_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int MATCH_W = $clog2(DEBOUNCE_SCANS + 1);

    typedef enum logic [1:0] {
        RES_NONE   = 2'd0,
        RES_SINGLE = 2'd1,
        RES_MULTI  = 2'd2
    } res_t;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESSED = 1'b1
    } state_t;

    if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 1 || REPEAT_DELAY_SCANS < 1 || REPEAT_PERIOD_SCANS < 1) begin : g_param_check
        $error("keypad_scan_debounce: parameter out of range");
    end

    logic [3:0]         rows_meta;
    logic [3:0]         rows_sync;
    logic [DIV_W-1:0]   div_cnt;
    logic [1:0]         col_idx;
    logic               dwell_end;
    logic               scan_done;
    logic [2:0]         hit_n;
    logic [1:0]         hit_row;
    res_t               acc_kind;
    logic [3:0]         acc_code;
    res_t               col_kind;
    logic [3:0]         col_code;
    res_t               prev_kind;
    logic [3:0]         prev_code;
    logic [MATCH_W-1:0] match_cnt;
    logic [MATCH_W-1:0] match_nxt;
    logic               stable;
    logic               rep_fire;
    state_t             state;

    assign dwell_end = (div_cnt == '0);
    assign scan_done = dwell_end && (col_idx == 2'd3);

    // Two-flop synchronizer; idle level of the pulled-up rows is all ones.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rows_meta <= 4'hF;
            rows_sync <= 4'hF;
        end else begin
            rows_meta <= rows;
            rows_sync <= rows_meta;
        end
    end

    // Dwell timer and rotating one-cold column drive.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_cnt <= DIV_W'(SCAN_DIV - 1);
            col_idx <= 2'd0;
            columns <= 4'b1110;
        end else if (dwell_end) begin
            div_cnt <= DIV_W'(SCAN_DIV - 1);
            col_idx <= col_idx + 2'd1;
            columns <= {columns[2:0], columns[3]};
        end else begin
            div_cnt <= div_cnt - DIV_W'(1);
        end
    end

    // Count low rows in the current column and remember which one.
    always_comb begin
        hit_n   = 3'd0;
        hit_row = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!rows_sync[i]) begin
                hit_n   = hit_n + 3'd1;
                hit_row = 2'(i);
            end
        end
    end

    // Fold this column's sample into the running scan result.
    always_comb begin
        col_kind = acc_kind;
        col_code = acc_code;
        if (hit_n > 3'd1) begin
            col_kind = RES_MULTI;
        end else if (hit_n == 3'd1) begin
            if (acc_kind == RES_NONE) begin
                col_kind = RES_SINGLE;
                col_code = {col_idx, hit_row};
            end else begin
                col_kind = RES_MULTI;
            end
        end
        if (col_kind == RES_MULTI) begin
            col_code = 4'd0;
        end
    end

    // Scan accumulator; restarts empty after the column-3 sample.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_kind <= RES_NONE;
            acc_code <= 4'd0;
        end else if (scan_done) begin
            acc_kind <= RES_NONE;
            acc_code <= 4'd0;
        end else if (dwell_end) begin
            acc_kind <= col_kind;
            acc_code <= col_code;
        end
    end

    // Next match count: saturating run length of identical scan results.
    always_comb begin
        match_nxt = MATCH_W'(1);
        if ((col_kind == prev_kind) && (col_code == prev_code)) begin
            if (match_cnt == MATCH_W'(DEBOUNCE_SCANS)) begin
                match_nxt = match_cnt;
            end else begin
                match_nxt = match_cnt + MATCH_W'(1);
            end
        end
    end

    assign stable = (match_nxt == MATCH_W'(DEBOUNCE_SCANS));

    // Previous scan result and its match count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev_kind <= RES_NONE;
            prev_code <= 4'd0;
            match_cnt <= '0;
        end else if (scan_done) begin
            prev_kind <= col_kind;
            prev_code <= col_code;
            match_cnt <= match_nxt;
        end
    end

`ifdef AUTOREPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY_SCANS > REPEAT_PERIOD_SCANS) ? REPEAT_DELAY_SCANS : REPEAT_PERIOD_SCANS;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    logic [REP_W-1:0] rep_cnt;
    logic [3:0]       held_code;
    logic             same_key;

    assign same_key = scan_done && stable && (state == PRESSED) &&
                      (col_kind == RES_SINGLE) && (col_code == held_code);
    assign rep_fire = same_key && (rep_cnt == REP_W'(1));

    // Scans-to-next-repeat down-counter; reloads on each repeat, clears on release.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rep_cnt   <= '0;
            held_code <= 4'd0;
        end else if (scan_done && stable) begin
            if ((state == IDLE) && (col_kind == RES_SINGLE)) begin
                rep_cnt   <= REP_W'(REPEAT_DELAY_SCANS);
                held_code <= col_code;
            end else if ((state == PRESSED) && (col_kind == RES_NONE)) begin
                rep_cnt <= '0;
            end else if (rep_fire) begin
                rep_cnt <= REP_W'(REPEAT_PERIOD_SCANS);
            end else if (same_key && (rep_cnt != '0)) begin
                rep_cnt <= rep_cnt - REP_W'(1);
            end
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    // Press/release FSM with registered event and held outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            value    <= 5'd0;
            key_held <= 1'b0;
        end else begin
            value <= 5'd0;
            if (scan_done && stable) begin
                case (state)
                    IDLE: begin
                        if (col_kind == RES_SINGLE) begin
                            value    <= {1'b1, col_code};
                            key_held <= 1'b1;
                            state    <= PRESSED;
                        end
                    end
                    PRESSED: begin
                        if (col_kind == RES_NONE) begin
                            key_held <= 1'b0;
                            state    <= IDLE;
                        end else if (rep_fire) begin
                            value <= {1'b1, col_code};
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
